// File: rtl/ifu.sv
// Instruction fetch stage: owns the PC, runs one valid/ready fetch at a time,
// and drives the predecoded IF/ID register with stall hold and redirect squash.
module ifu #(
    parameter logic [31:0] RESET_PC  = 32'h8000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    output logic [31:0] IDReg_PC,
    output logic [31:0] IDReg_Instr,
    output logic [6:0]  IDReg_op,
    output logic [4:0]  IDReg_Regrd,
    output logic [2:0]  IDReg_Func3,
    output logic [4:0]  IDReg_rs1,
    output logic [4:0]  IDReg_rs2,
    output logic [6:0]  IDReg_Func7,
    output logic        if_diffen
);

    typedef enum logic [1:0] {
        S_REQ,
        S_WAIT,
        S_HOLD,
        S_KILL
    } state_t;

    state_t      state;
    state_t      state_next;
    logic [31:0] pc;
    logic [31:0] hold_pc;
    logic [31:0] hold_instr;
    logic [31:0] id_pc;
    logic [31:0] id_instr;
    logic        id_valid;
    logic        rsp_in_wait;
    logic        unused_redirect_lsbs;

    // Fetch addresses are word aligned; the low redirect bits are dropped.
    assign unused_redirect_lsbs = ^redirect_pc[1:0];
    assign rsp_in_wait          = (state == S_WAIT) && imem_rsp_valid;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_REQ;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        if (redirect_valid) begin
            // A request already accepted must have its response drained in S_KILL.
            unique case (state)
                S_REQ:   state_next = imem_req_ready ? S_KILL : S_REQ;
                S_WAIT:  state_next = imem_rsp_valid ? S_REQ : S_KILL;
                S_HOLD:  state_next = S_REQ;
                S_KILL:  state_next = imem_rsp_valid ? S_REQ : S_KILL;
                default: state_next = S_REQ;
            endcase
        end else begin
            unique case (state)
                S_REQ:   if (imem_req_ready) state_next = S_WAIT;
                S_WAIT:  if (imem_rsp_valid) state_next = stall ? S_HOLD : S_REQ;
                S_HOLD:  if (!stall) state_next = S_REQ;
                S_KILL:  if (imem_rsp_valid) state_next = S_REQ;
                default: state_next = S_REQ;
            endcase
        end
    end

    always_comb begin
        imem_req_valid = (state == S_REQ) && !rst;
        imem_req_addr  = pc;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc         <= RESET_PC;
            hold_pc    <= '0;
            hold_instr <= '0;
            id_pc      <= '0;
            id_instr   <= NOP_INSTR;
            id_valid   <= 1'b0;
        end else if (redirect_valid) begin
            pc       <= {redirect_pc[31:2], 2'b00};
            id_pc    <= '0;
            id_instr <= NOP_INSTR;
            id_valid <= 1'b0;
        end else if (stall) begin
            // IF/ID is frozen; a response landing now is parked for later.
            if (rsp_in_wait) begin
                hold_pc    <= pc;
                hold_instr <= imem_rsp_data;
            end
        end else if (rsp_in_wait) begin
            id_pc    <= pc;
            id_instr <= imem_rsp_data;
            id_valid <= 1'b1;
            pc       <= pc + 32'd4;
        end else if (state == S_HOLD) begin
            id_pc    <= hold_pc;
            id_instr <= hold_instr;
            id_valid <= 1'b1;
            pc       <= hold_pc + 32'd4;
        end else begin
            id_pc    <= '0;
            id_instr <= NOP_INSTR;
            id_valid <= 1'b0;
        end
    end

    assign IDReg_PC    = id_pc;
    assign IDReg_Instr = id_instr;
    assign IDReg_op    = id_instr[6:0];
    assign IDReg_Regrd = id_instr[11:7];
    assign IDReg_Func3 = id_instr[14:12];
    assign IDReg_rs1   = id_instr[19:15];
    assign IDReg_rs2   = id_instr[24:20];
    assign IDReg_Func7 = id_instr[31:25];
    assign if_diffen   = id_valid;

endmodule

// File: tb/tb_ifu.sv
// Directed bench for ifu: expected IF/ID entries are queued when a response
// is driven and popped when the stage presents them.
module tb_ifu;

    localparam logic [31:0] RESET_PC  = 32'h8000_0000;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic [31:0] IDReg_PC;
    logic [31:0] IDReg_Instr;
    logic [6:0]  IDReg_op;
    logic [4:0]  IDReg_Regrd;
    logic [2:0]  IDReg_Func3;
    logic [4:0]  IDReg_rs1;
    logic [4:0]  IDReg_rs2;
    logic [6:0]  IDReg_Func7;
    logic        if_diffen;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } entry_t;

    entry_t sb_q[$];
    int     checks   = 0;
    int     failures = 0;

    ifu #(.RESET_PC(RESET_PC), .NOP_INSTR(NOP_INSTR)) dut (
        .clk            (clk),
        .rst            (rst),
        .stall          (stall),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .IDReg_PC       (IDReg_PC),
        .IDReg_Instr    (IDReg_Instr),
        .IDReg_op       (IDReg_op),
        .IDReg_Regrd    (IDReg_Regrd),
        .IDReg_Func3    (IDReg_Func3),
        .IDReg_rs1      (IDReg_rs1),
        .IDReg_rs2      (IDReg_rs2),
        .IDReg_Func7    (IDReg_Func7),
        .if_diffen      (if_diffen)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            failures++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    task automatic check_output_bubble(input string tag);
        check({tag, "_diffen"}, {31'd0, if_diffen}, 32'd0);
        check({tag, "_instr"}, IDReg_Instr, NOP_INSTR);
        check({tag, "_pc"}, IDReg_PC, 32'd0);
        check({tag, "_op"}, {25'd0, IDReg_op}, 32'h13);
        check({tag, "_rd"}, {27'd0, IDReg_Regrd}, 32'd0);
    endtask

    task automatic check_output_held(input string tag, input logic [31:0] pc, input logic [31:0] instr);
        check({tag, "_diffen"}, {31'd0, if_diffen}, 32'd1);
        check({tag, "_pc"}, IDReg_PC, pc);
        check({tag, "_instr"}, IDReg_Instr, instr);
    endtask

    task automatic check_output_entry(input string tag);
        entry_t e;
        if (sb_q.size() == 0) begin
            checks++;
            failures++;
            $error("[TB] FAIL %s observed=entry expected=scoreboard_item", tag);
        end else begin
            e = sb_q.pop_front();
            check_output_held(tag, e.pc, e.instr);
            check({tag, "_op"}, {25'd0, IDReg_op}, {25'd0, e.instr[6:0]});
            check({tag, "_rd"}, {27'd0, IDReg_Regrd}, {27'd0, e.instr[11:7]});
            check({tag, "_f3"}, {29'd0, IDReg_Func3}, {29'd0, e.instr[14:12]});
            check({tag, "_rs1"}, {27'd0, IDReg_rs1}, {27'd0, e.instr[19:15]});
            check({tag, "_rs2"}, {27'd0, IDReg_rs2}, {27'd0, e.instr[24:20]});
            check({tag, "_f7"}, {25'd0, IDReg_Func7}, {25'd0, e.instr[31:25]});
        end
    endtask

    // Zero-wait fetch starting in S_REQ: accept, respond next cycle.
    task automatic apply_stimulus_fetch(input string tag, input logic [31:0] data, input logic [31:0] pc);
        imem_req_ready = 1'b1;
        imem_rsp_valid = 1'b0;
        tick();
        check({tag, "_wait_valid"}, {31'd0, imem_req_valid}, 32'd0);
        check_output_bubble({tag, "_gap"});
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = data;
        sb_q.push_back('{pc: pc, instr: data});
        tick();
        imem_rsp_valid = 1'b0;
        check_output_entry(tag);
    endtask

    initial begin
        rst = 1'b1; stall = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
        imem_req_ready = 1'b0; imem_rsp_valid = 1'b0; imem_rsp_data = '0;
        tick();
        tick();
        check("rst_req_valid", {31'd0, imem_req_valid}, 32'd0);
        check_output_bubble("rst");
        rst = 1'b0;
        #1;
        check("first_req_valid", {31'd0, imem_req_valid}, 32'd1);
        check("first_req_addr", imem_req_addr, RESET_PC);

        // Back-to-back zero-wait fetches
        apply_stimulus_fetch("t1a", 32'h0050_0093, 32'h8000_0000);
        check("t1a_rd", {27'd0, IDReg_Regrd}, 32'd1);
        check("t1a_rs1", {27'd0, IDReg_rs1}, 32'd0);
        check("t1a_op", {25'd0, IDReg_op}, 32'h13);
        check("t1a_next_addr", imem_req_addr, 32'h8000_0004);
        apply_stimulus_fetch("t1b", 32'h0010_8113, 32'h8000_0004);
        check("t1b_rd", {27'd0, IDReg_Regrd}, 32'd2);
        check("t1b_rs1", {27'd0, IDReg_rs1}, 32'd1);

        // Stall for three cycles across a response
        stall = 1'b1; imem_req_ready = 1'b1;
        tick();
        check_output_held("t2_acc", 32'h8000_0004, 32'h0010_8113);
        imem_req_ready = 1'b0; imem_rsp_valid = 1'b1; imem_rsp_data = 32'h00C0_0193;
        tick();
        imem_rsp_valid = 1'b0;
        check_output_held("t2_rsp", 32'h8000_0004, 32'h0010_8113);
        tick();
        check_output_held("t2_hold", 32'h8000_0004, 32'h0010_8113);
        check("t2_hold_valid", {31'd0, imem_req_valid}, 32'd0);
        stall = 1'b0;
        sb_q.push_back('{pc: 32'h8000_0008, instr: 32'h00C0_0193});
        tick();
        check_output_entry("t2_release");
        check("t2_next_addr", imem_req_addr, 32'h8000_000C);
        check("t2_next_valid", {31'd0, imem_req_valid}, 32'd1);
        tick();
        check_output_bubble("t2_once");

        // Redirect while waiting; late response is killed
        imem_req_ready = 1'b1;
        tick();
        imem_req_ready = 1'b0; redirect_valid = 1'b1; redirect_pc = 32'h8000_0103;
        tick();
        redirect_valid = 1'b0;
        check_output_bubble("t3_redir");
        check("t3_kill_valid", {31'd0, imem_req_valid}, 32'd0);
        tick();
        check("t3_kill_valid2", {31'd0, imem_req_valid}, 32'd0);
        imem_rsp_valid = 1'b1; imem_rsp_data = 32'hDEAD_BEEF;
        tick();
        imem_rsp_valid = 1'b0;
        check_output_bubble("t3_drop");
        check("t3_req_valid", {31'd0, imem_req_valid}, 32'd1);
        check("t3_req_addr", imem_req_addr, 32'h8000_0100);

        // Redirect and stall together on the response cycle
        imem_req_ready = 1'b1;
        tick();
        imem_req_ready = 1'b0; imem_rsp_valid = 1'b1; imem_rsp_data = 32'h0000_0073;
        stall = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h8000_0200;
        tick();
        imem_rsp_valid = 1'b0; stall = 1'b0; redirect_valid = 1'b0;
        check_output_bubble("t4_redir");
        check("t4_req_valid", {31'd0, imem_req_valid}, 32'd1);
        check("t4_req_addr", imem_req_addr, 32'h8000_0200);
        apply_stimulus_fetch("t4_fetch", 32'h0020_8233, 32'h8000_0200);

        // Ready held low, then redirect without a kill
        for (int i = 0; i < 5; i++) begin
            tick();
            check("t5_wait_valid", {31'd0, imem_req_valid}, 32'd1);
            check("t5_wait_addr", imem_req_addr, 32'h8000_0204);
        end
        redirect_valid = 1'b1; redirect_pc = 32'h8000_0300;
        tick();
        redirect_valid = 1'b0;
        check("t5_redir_valid", {31'd0, imem_req_valid}, 32'd1);
        check("t5_redir_addr", imem_req_addr, 32'h8000_0300);
        check_output_bubble("t5_redir");
        apply_stimulus_fetch("t5_fetch", 32'h0030_A2B3, 32'h8000_0300);

        // PC wraps past the top of the address space
        redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFE;
        tick();
        redirect_valid = 1'b0;
        check("wrap_addr", imem_req_addr, 32'hFFFF_FFFC);
        apply_stimulus_fetch("wrap_fetch", 32'h0040_0313, 32'hFFFF_FFFC);
        check("wrap_next_addr", imem_req_addr, 32'h0000_0000);

        // Reset while waiting, then a stale response
        imem_req_ready = 1'b1;
        tick();
        imem_req_ready = 1'b0; rst = 1'b1;
        tick();
        check("t6_rst_valid", {31'd0, imem_req_valid}, 32'd0);
        check_output_bubble("t6_rst");
        rst = 1'b0; imem_rsp_valid = 1'b1; imem_rsp_data = 32'h1234_5678;
        #1;
        check("t6_req_valid", {31'd0, imem_req_valid}, 32'd1);
        check("t6_req_addr", imem_req_addr, RESET_PC);
        tick();
        imem_rsp_valid = 1'b0;
        check_output_bubble("t6_stale");
        apply_stimulus_fetch("t6_fetch", 32'h0050_0093, RESET_PC);

        check("sb_empty", sb_q.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ifu.md
# ifu

Instruction fetch stage of the five-stage in-order RV32 pipeline, directly upstream of decode. Holds the PC, issues one request at a time on a valid/ready instruction-memory port, predecodes the returned word into register fields, and drives the IF/ID pipeline register (`IDReg_*`, `if_diffen`) consumed by decode. Honours hazard stalls through a one-entry hold buffer and branch redirects by squashing in-flight fetches.

## Interface

Parameters:
- `RESET_PC`, default `32'h8000_0000`: first fetch address after reset.
- `NOP_INSTR`, default `32'h0000_0013`: bubble encoding (`addi x0,x0,0`).

Ports (widths from `define.v`: DATA 32, ADDR 5, OPCODE 7, FUNC3 3, FUNC7 7):
- `clk` in 1: the single clock; all state updates on rising edge.
- `rst` in 1: reset, synchronous and active-high.
- `stall` in 1: hazard unit; hold the IF/ID register.
- `redirect_valid` in 1: branch/jump resolved taken or mispredicted; flush.
- `redirect_pc` in 32: new fetch PC; bits [1:0] forced to 0.
- `imem_req_valid` out 1: request valid.
- `imem_req_ready` in 1: memory accepts request this cycle.
- `imem_req_addr` out 32: fetch address (current PC).
- `imem_rsp_valid` in 1: response data valid.
- `imem_rsp_data` in 32: fetched instruction word.
- `IDReg_PC`, `IDReg_Instr` out 32: PC and instruction of the IF/ID entry.
- `IDReg_op` out 7, `IDReg_Regrd` out 5, `IDReg_Func3` out 3, `IDReg_rs1` out 5, `IDReg_rs2` out 5, `IDReg_Func7` out 7: predecoded fields.
- `if_diffen` out 1: IF/ID entry is a real instruction (difftest commit enable); 0 for a bubble.

## Operation

- Predecode, pure slicing of the latched word: op=[6:0], rd=[11:7], func3=[14:12], rs1=[19:15], rs2=[24:20], func7=[31:25].
- Bubble: `IDReg_Instr`=`NOP_INSTR`, fields sliced from it (op=`0010011`, others 0), `IDReg_PC`=0, `if_diffen`=0.
- FSM states:
  - `S_REQ`: `imem_req_valid`=1, `imem_req_addr`=pc. `imem_req_ready` → `S_WAIT`.
  - `S_WAIT`: await `imem_rsp_valid`. On response, if `stall`=0: write IF/ID, pc+=4 → `S_REQ`. If `stall`=1: capture word and pc in hold buffer → `S_HOLD`.
  - `S_HOLD`: when `stall` falls, write IF/ID from buffer, pc+=4 → `S_REQ`.
  - `S_KILL`: await `imem_rsp_valid`, discard data → `S_REQ`.
- `imem_req_valid` is 0 in every state other than `S_REQ` and while `rst`=1.
- IF/ID update rule each cycle: `stall`=1 holds it. Otherwise a delivered instruction is loaded, or a bubble if none is delivered.
- Redirect has priority over stall and all else. In the same cycle it sets pc←{redirect_pc[31:2],2'b00} and loads a bubble into IF/ID. State effects:
  - `S_REQ` with ready=0 → stay `S_REQ`.
  - `S_REQ` with ready=1 → `S_KILL`.
  - `S_WAIT` without response → `S_KILL`.
  - `S_WAIT` with response in the same cycle → discard → `S_REQ`.
  - `S_HOLD` → drop buffer → `S_REQ`.
  - `S_KILL` → stays `S_KILL` unless the response arrives that cycle, then → `S_REQ`.
- `imem_rsp_valid` in `S_REQ`/`S_HOLD` is ignored.
- pc wraps modulo 2^32 (`32'hFFFF_FFFC`+4 = 0).

## Timing

- Reset (`rst`=1 at an edge): pc=`RESET_PC`, state=`S_REQ`, hold buffer empty, IF/ID=bubble, `if_diffen`=0. Reset mid-fetch abandons the outstanding request; the memory is reset on the same `rst`.
- First request is visible the cycle after `rst` deasserts.
- Request accepted at edge N, response in cycle N+k (k≥1): IF/ID is valid from edge N+k. Best-case throughput is one instruction per 2 cycles.
- Redirect asserted in cycle R: IF/ID is bubble after edge R. Request to `redirect_pc` issues in cycle R+1, or after the killed response when in `S_KILL`.
- Stall releasing in cycle S from `S_HOLD`: held instruction appears in IF/ID after edge S. No instruction is lost or duplicated.

## Test plan

- Reset, zero-wait memory (ready=1, rsp one cycle later), words 0x00500093, 0x00108113: IF/ID shows PC 0x80000000 then 0x80000004 with `if_diffen`=1 on alternate cycles. Fields rd=1, rs1=0, op=0x13, then rd=2, rs1=1.
- `stall`=1 for 3 cycles while a response arrives: response is buffered and IF/ID is held unchanged. After release, the buffered PC appears once and the next fetch address is +4.
- Redirect to 0x80000103 while in `S_WAIT`, response arrives 2 cycles later: response discarded, IF/ID is a bubble, next `imem_req_addr`=0x80000100.
- Redirect and `stall` asserted together in the response cycle: bubble is loaded, nothing is buffered, next request goes to the redirect PC.
- `imem_req_ready` held low 5 cycles, then redirect: address changes to the redirect PC while `imem_req_valid` stays 1, and no kill occurs.
- `rst` asserted in `S_WAIT`, then a stale `imem_rsp_valid`: response ignored, first request is to `RESET_PC`, and `if_diffen`=0 until a real fetch completes.
